// File: rtl/packet_flitizer_if.sv
// Descriptor, flit, credit and status signals of the packet flitizer.
// FLITIZER_STATS_EN adds the stat_pkts/stat_flits counters.
interface packet_flitizer_if;
    localparam int unsigned NODE_W = 10;
    localparam int unsigned VC_W   = 3;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned STAT_W = 32;

    logic              pkt_valid;
    logic              pkt_ready;
    logic [NODE_W-1:0] pkt_src;
    logic [NODE_W-1:0] pkt_dest;
    logic [VC_W-1:0]   pkt_vc;
    logic [LEN_W-1:0]  pkt_num_flits;

    logic              flit_valid;
    logic              flit_ready;
    logic              flit_head;
    logic              flit_tail;
    logic [NODE_W-1:0] flit_src;
    logic [NODE_W-1:0] flit_dest;
    logic [VC_W-1:0]   flit_vc;
    logic [LEN_W-1:0]  flit_seq;

    logic              credit_valid;
    logic [VC_W-1:0]   credit_vc;
    logic              busy;

`ifdef FLITIZER_STATS_EN
    logic [STAT_W-1:0] stat_pkts;
    logic [STAT_W-1:0] stat_flits;

    modport slave (
        input  pkt_valid, pkt_src, pkt_dest, pkt_vc, pkt_num_flits,
        output pkt_ready,
        output flit_valid, flit_head, flit_tail, flit_src, flit_dest, flit_vc, flit_seq,
        input  flit_ready,
        input  credit_valid, credit_vc,
        output busy, stat_pkts, stat_flits
    );

    modport master (
        output pkt_valid, pkt_src, pkt_dest, pkt_vc, pkt_num_flits,
        input  pkt_ready,
        input  flit_valid, flit_head, flit_tail, flit_src, flit_dest, flit_vc, flit_seq,
        output flit_ready,
        output credit_valid, credit_vc,
        input  busy, stat_pkts, stat_flits
    );
`else
    modport slave (
        input  pkt_valid, pkt_src, pkt_dest, pkt_vc, pkt_num_flits,
        output pkt_ready,
        output flit_valid, flit_head, flit_tail, flit_src, flit_dest, flit_vc, flit_seq,
        input  flit_ready,
        input  credit_valid, credit_vc,
        output busy
    );

    modport master (
        output pkt_valid, pkt_src, pkt_dest, pkt_vc, pkt_num_flits,
        input  pkt_ready,
        input  flit_valid, flit_head, flit_tail, flit_src, flit_dest, flit_vc, flit_seq,
        output flit_ready,
        output credit_valid, credit_vc,
        input  busy
    );
`endif
endinterface

// File: rtl/packet_flitizer.sv
// Serialises packet descriptors into credit-gated head/body/tail flits.
// Optional FLITIZER_STATS_EN adds packet and flit handshake counters.
module packet_flitizer #(
    parameter int unsigned NUM_VC  = 8,
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CW      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    packet_flitizer_if.slave  bus
);
    localparam int unsigned NODE_W = 10;
    localparam int unsigned VC_W   = 3;
    localparam int unsigned LEN_W  = 16;

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic              pkt_ready_q;
    logic              flit_valid_q, flit_valid_d;
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic              busy_q;
    logic [NODE_W-1:0] src_q, src_d;
    logic [NODE_W-1:0] dest_q, dest_d;
    logic [VC_W-1:0]   vc_q, vc_d;
    logic [LEN_W-1:0]  seq_q, seq_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CW-1:0]     credit_q [NUM_VC];
    logic [CW-1:0]     credit_d [NUM_VC];
    logic              accept;
    logic              flit_hs;

    // Next packet state, credit bookkeeping and lookahead of the flit outputs.
    always_comb begin
        accept  = pkt_ready_q && bus.pkt_valid;
        flit_hs = flit_valid_q && bus.flit_ready;
        state_d = state_q;
        src_d   = src_q;
        dest_d  = dest_q;
        vc_d    = vc_q;
        seq_d   = seq_q;
        len_d   = len_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                    src_d   = bus.pkt_src;
                    dest_d  = bus.pkt_dest;
                    vc_d    = bus.pkt_vc;
                    seq_d   = '0;
                    len_d   = (bus.pkt_num_flits == '0) ? LEN_W'(1) : bus.pkt_num_flits;
                end
            end
            SEND: begin
                if (flit_hs) begin
                    seq_d = seq_q + LEN_W'(1);
                    if (tail_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int unsigned v = 0; v < NUM_VC; v++) begin
            logic inc;
            logic dec;
            inc = bus.credit_valid && (32'(bus.credit_vc) == v);
            dec = flit_hs && (32'(vc_q) == v);
            credit_d[v] = credit_q[v];
            if (inc && !dec && (credit_q[v] != CW'(CREDITS)))
                credit_d[v] = credit_q[v] + CW'(1);
            else if (dec && !inc)
                credit_d[v] = credit_q[v] - CW'(1);
        end

        // Registered outputs follow the post-edge state so they appear without an extra cycle.
        flit_valid_d = (state_d == SEND) && (credit_d[vc_d] != '0);
        head_d       = (state_d == SEND) && (seq_d == '0);
        tail_d       = (state_d == SEND) && (seq_d == len_d - LEN_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pkt_ready_q  <= 1'b1;
            flit_valid_q <= 1'b0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            busy_q       <= 1'b0;
            src_q        <= '0;
            dest_q       <= '0;
            vc_q         <= '0;
            seq_q        <= '0;
            len_q        <= '0;
            for (int unsigned v = 0; v < NUM_VC; v++) credit_q[v] <= CW'(CREDITS);
        end else begin
            state_q      <= state_d;
            pkt_ready_q  <= (state_d == IDLE);
            flit_valid_q <= flit_valid_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            busy_q       <= (state_d == SEND);
            src_q        <= src_d;
            dest_q       <= dest_d;
            vc_q         <= vc_d;
            seq_q        <= seq_d;
            len_q        <= len_d;
            for (int unsigned v = 0; v < NUM_VC; v++) credit_q[v] <= credit_d[v];
        end
    end

`ifdef FLITIZER_STATS_EN
    localparam int unsigned STAT_W = 32;
    logic [STAT_W-1:0] stat_pkts_q;
    logic [STAT_W-1:0] stat_flits_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_pkts_q  <= '0;
            stat_flits_q <= '0;
        end else if (flit_hs) begin
            stat_flits_q <= stat_flits_q + STAT_W'(1);
            if (tail_q) stat_pkts_q <= stat_pkts_q + STAT_W'(1);
        end
    end

    assign bus.stat_pkts  = stat_pkts_q;
    assign bus.stat_flits = stat_flits_q;
`endif

    assign bus.pkt_ready  = pkt_ready_q;
    assign bus.flit_valid = flit_valid_q;
    assign bus.flit_head  = head_q;
    assign bus.flit_tail  = tail_q;
    assign bus.flit_src   = src_q;
    assign bus.flit_dest  = dest_q;
    assign bus.flit_vc    = vc_q;
    assign bus.flit_seq   = seq_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_packet_flitizer.sv
// Self-checking bench for packet_flitizer: packet-level model plus directed scenarios.
module tb_packet_flitizer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    packet_flitizer_if bus ();
    packet_flitizer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the packet in flight, its next flit index and per-VC credit counts.
    bit m_ok = 1'b0;
    bit m_busy = 1'b0;
    int m_src, m_dest, m_vc, m_len, m_seq;
    int m_cred [8];
    int m_pkts, m_flits;
    int cyc = 0;

    always @(posedge clk) begin : model
        bit hs;
        bit ret;
        bit use_v;
        cyc++;
        if (!rst_n) begin
            m_ok = 1'b1;
            m_busy = 1'b0;
            m_seq = 0;
            for (int v = 0; v < 8; v++) m_cred[v] = 4;
            m_pkts = 0;
            m_flits = 0;
        end else if (m_ok) begin
            hs = m_busy && (m_cred[m_vc] > 0) && bus.flit_ready;
            for (int v = 0; v < 8; v++) begin
                ret   = bus.credit_valid && (int'(bus.credit_vc) == v);
                use_v = hs && (m_vc == v);
                if (ret && !use_v && m_cred[v] < 4) m_cred[v] = m_cred[v] + 1;
                else if (use_v && !ret) m_cred[v] = m_cred[v] - 1;
            end
            if (hs) begin
                m_flits++;
                m_seq++;
                if (m_seq == m_len) begin
                    m_busy = 1'b0;
                    m_pkts++;
                end
            end else if (!m_busy && bus.pkt_valid) begin
                m_src  = int'(bus.pkt_src);
                m_dest = int'(bus.pkt_dest);
                m_vc   = int'(bus.pkt_vc);
                m_len  = (bus.pkt_num_flits == 16'd0) ? 1 : int'(bus.pkt_num_flits);
                m_seq  = 0;
                m_busy = 1'b1;
            end
        end
    end

    // Observed handshakes, tagged with the clock edge at which they complete.
    int obs_seq[$], obs_head[$], obs_tail[$], obs_edge[$], acc_edge[$];
    bit prev_stall = 1'b0;
    logic [22:0] prev_a;
    logic [17:0] prev_b;

    always @(negedge clk) begin : compare
        bit exp_v;
        if (m_ok && rst_n) begin
            exp_v = m_busy && (m_cred[m_vc] > 0);
            check("pkt_ready", 32'(bus.pkt_ready), 32'(!m_busy));
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("flit_valid", 32'(bus.flit_valid), 32'(exp_v));
            if (exp_v) begin
                check("flit_head", 32'(bus.flit_head), 32'(m_seq == 0));
                check("flit_tail", 32'(bus.flit_tail), 32'(m_seq == m_len - 1));
                check("flit_src", 32'(bus.flit_src), 32'(m_src));
                check("flit_dest", 32'(bus.flit_dest), 32'(m_dest));
                check("flit_vc", 32'(bus.flit_vc), 32'(m_vc));
                check("flit_seq", 32'(bus.flit_seq), 32'(m_seq));
            end
            if (prev_stall) begin
                check("stall_valid", 32'(bus.flit_valid), 32'd1);
                check("stall_route", 32'({bus.flit_src, bus.flit_dest, bus.flit_vc}), 32'(prev_a));
                check("stall_seq", 32'({bus.flit_head, bus.flit_tail, bus.flit_seq}), 32'(prev_b));
            end
`ifdef FLITIZER_STATS_EN
            check("stat_pkts", bus.stat_pkts, 32'(m_pkts));
            check("stat_flits", bus.stat_flits, 32'(m_flits));
`endif
            prev_stall = bus.flit_valid && !bus.flit_ready;
            prev_a = {bus.flit_src, bus.flit_dest, bus.flit_vc};
            prev_b = {bus.flit_head, bus.flit_tail, bus.flit_seq};
            if (bus.flit_valid && bus.flit_ready) begin
                obs_seq.push_back(int'(bus.flit_seq));
                obs_head.push_back(int'(bus.flit_head));
                obs_tail.push_back(int'(bus.flit_tail));
                obs_edge.push_back(cyc + 1);
            end
            if (bus.pkt_valid && bus.pkt_ready) acc_edge.push_back(cyc + 1);
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int src, input int dest, input int vc, input int nf);
        check("ready_before_accept", 32'(bus.pkt_ready), 32'd1);
        bus.pkt_valid     = 1'b1;
        bus.pkt_src       = 10'(src);
        bus.pkt_dest      = 10'(dest);
        bus.pkt_vc        = 3'(vc);
        bus.pkt_num_flits = 16'(nf);
        step();
        bus.pkt_valid = 1'b0;
    endtask

    task automatic wait_obs(input string name, input int target, input int budget);
        int n = 0;
        while (obs_seq.size() < target && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(obs_seq.size()), 32'(target));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        int abase;
        int n;
        bus.pkt_valid = 1'b0; bus.pkt_src = '0; bus.pkt_dest = '0; bus.pkt_vc = '0;
        bus.pkt_num_flits = '0; bus.flit_ready = 1'b0; bus.credit_valid = 1'b0; bus.credit_vc = '0;
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_pkt_ready", 32'(bus.pkt_ready), 32'd1);
        check("rst_flit_valid", 32'(bus.flit_valid), 32'd0);
        check("rst_head_tail", 32'({bus.flit_head, bus.flit_tail}), 32'd0);
        check("rst_fields", 32'({bus.flit_src, bus.flit_dest, bus.flit_vc}), 32'd0);
        check("rst_seq", 32'(bus.flit_seq), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        step();

        // Single-flit packet.
        bus.flit_ready = 1'b1;
        base = obs_seq.size();
        send_pkt(5, 9, 2, 1);
        check("single_valid", 32'(bus.flit_valid), 32'd1);
        check("single_head_tail", 32'({bus.flit_head, bus.flit_tail}), 32'd3);
        check("single_seq", 32'(bus.flit_seq), 32'd0);
        check("single_vc", 32'(bus.flit_vc), 32'd2);
        check("single_src_dest", 32'({bus.flit_src, bus.flit_dest}), 32'({10'd5, 10'd9}));
        step();
        check("single_idle_ready", 32'(bus.pkt_ready), 32'd1);
        check("single_idle_valid", 32'(bus.flit_valid), 32'd0);
        check("single_count", 32'(obs_seq.size()), 32'(base + 1));

        // Four flits with toggling backpressure.
        bus.flit_ready = 1'b0;
        base = obs_seq.size();
        send_pkt(11, 12, 0, 4);
        n = 0;
        while (obs_seq.size() < base + 4 && n < 40) begin
            bus.flit_ready = (n % 2 == 0);
            step();
            n++;
        end
        bus.flit_ready = 1'b1;
        check("bp_count", 32'(obs_seq.size()), 32'(base + 4));
        for (int k = 0; k < 4; k++) begin
            if (base + k < obs_seq.size()) begin
                check("bp_seq", 32'(obs_seq[base + k]), 32'(k));
                check("bp_head", 32'(obs_head[base + k]), 32'(k == 0));
                check("bp_tail", 32'(obs_tail[base + k]), 32'(k == 3));
            end
        end
        step();

        // Credit exhaustion on vc1, refilled by two returns.
        base = obs_seq.size();
        send_pkt(1, 2, 1, 6);
        repeat (8) step();
        check("exhaust_count", 32'(obs_seq.size()), 32'(base + 4));
        check("exhaust_valid", 32'(bus.flit_valid), 32'd0);
        check("exhaust_busy", 32'(bus.busy), 32'd1);
        bus.credit_vc = 3'd1;
        bus.credit_valid = 1'b1; step(); bus.credit_valid = 1'b0;
        step(); step();
        bus.credit_valid = 1'b1; step(); bus.credit_valid = 1'b0;
        wait_obs("exhaust_resume", base + 6, 10);
        if (obs_seq.size() == base + 6) begin
            check("exhaust_last_seq", 32'(obs_seq[base + 5]), 32'd5);
            check("exhaust_last_tail", 32'(obs_tail[base + 5]), 32'd1);
        end
        step();

        // vc3: drain to 2, hold through simultaneous returns, saturate at 4.
        base = obs_seq.size();
        send_pkt(3, 3, 3, 2);
        wait_obs("vc3_drain", base + 2, 10);
        step();
        base = obs_seq.size();
        send_pkt(3, 4, 3, 2);
        bus.credit_vc = 3'd3;
        bus.credit_valid = 1'b1;
        step(); step();
        bus.credit_valid = 1'b0;
        check("simul_count", 32'(obs_seq.size()), 32'(base + 2));
        bus.credit_valid = 1'b1;
        repeat (3) step();
        bus.credit_valid = 1'b0;
        base = obs_seq.size();
        send_pkt(3, 5, 3, 6);
        repeat (8) step();
        check("sat_count", 32'(obs_seq.size()), 32'(base + 4));
        check("sat_valid", 32'(bus.flit_valid), 32'd0);
        bus.credit_valid = 1'b1;
        step(); step();
        bus.credit_valid = 1'b0;
        wait_obs("sat_resume", base + 6, 10);
        step();

        // Zero-length packet followed by a pending descriptor.
        base = obs_seq.size();
        bus.pkt_valid = 1'b1; bus.pkt_src = 10'd20; bus.pkt_dest = 10'd21;
        bus.pkt_vc = 3'd4; bus.pkt_num_flits = 16'd0;
        step();
        bus.pkt_src = 10'd22; bus.pkt_dest = 10'd23; bus.pkt_vc = 3'd5; bus.pkt_num_flits = 16'd1;
        check("zero_head_tail", 32'({bus.flit_head, bus.flit_tail}), 32'd3);
        check("zero_seq", 32'(bus.flit_seq), 32'd0);
        abase = acc_edge.size();
        n = 0;
        while (acc_edge.size() < abase + 1 && n < 10) begin
            step();
            n++;
        end
        bus.pkt_valid = 1'b0;
        check("b2b_accepted", 32'(acc_edge.size()), 32'(abase + 1));
        if (acc_edge.size() == abase + 1 && obs_seq.size() > base)
            check("b2b_gap", 32'(acc_edge[abase] - obs_edge[base]), 32'd1);
        wait_obs("b2b_second", base + 2, 10);
        step();

        // Reset in the middle of an 8-flit packet.
        send_pkt(30, 31, 6, 8);
        step(); step();
        check("midrst_seq", 32'(bus.flit_seq), 32'd2);
        rst_n = 1'b0;
        step();
        check("midrst_valid", 32'(bus.flit_valid), 32'd0);
        check("midrst_ready", 32'(bus.pkt_ready), 32'd1);
        check("midrst_busy", 32'(bus.busy), 32'd0);
`ifdef FLITIZER_STATS_EN
        check("stats_rst_pkts", bus.stat_pkts, 32'd0);
        check("stats_rst_flits", bus.stat_flits, 32'd0);
`endif
        rst_n = 1'b1;
        step();
        base = obs_seq.size();
        send_pkt(1, 1, 0, 1);
        wait_obs("stats_pkt1", base + 1, 10);
        step();
        send_pkt(1, 1, 2, 4);
        wait_obs("stats_pkt2", base + 5, 10);
        step();
`ifdef FLITIZER_STATS_EN
        check("stats_pkts", bus.stat_pkts, 32'd2);
        check("stats_flits", bus.stat_flits, 32'd5);
`endif
        // vc1 was drained before reset; a full budget of 4 proves the credit reset.
        base = obs_seq.size();
        send_pkt(2, 2, 1, 5);
        repeat (8) step();
        check("rst_cred_count", 32'(obs_seq.size()), 32'(base + 4));
        check("rst_cred_valid", 32'(bus.flit_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
